bin_to_bcd_seq: RTL and testbench

//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).

---
 rtl/bin_to_bcd_seq.sv | 111 +++++++++++
 tb/tb_bin_to_bcd_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: shift-and-add-3, one input bit per clock,
// with valid/ready handshakes on both sides.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  ovf
);

    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam int BCD_W = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t             state_q, state_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [BCD_W-1:0]   dig_q, dig_d;
    logic               flag_q, flag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;

    logic [BCD_W-1:0]   dig_adj;
    logic [BCD_W-1:0]   dig_sh;
    logic               carry_out;

    // Digit correction is per-nibble; no carry crosses digit boundaries.
    always_comb begin
        dig_adj = dig_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (dig_q[4*k +: 4] >= 4'd5) begin
                dig_adj[4*k +: 4] = dig_q[4*k +: 4] + 4'd3;
            end
        end
        dig_sh    = {dig_adj[BCD_W-2:0], bin_q[BIN_W-1]};
        carry_out = dig_adj[BCD_W-1];
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        dig_d   = dig_q;
        flag_d  = flag_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    bin_d   = bin_in;
                    dig_d   = '0;
                    flag_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                dig_d  = dig_sh;
                bin_d  = bin_q << 1;
                flag_d = flag_q | carry_out;
                cnt_d  = cnt_q + 1'b1;
                // Last shift publishes straight from the shifted value.
                if (cnt_q == CNT_W'(BIN_W - 1)) begin
                    bcd_d   = dig_sh;
                    ovf_d   = flag_q | carry_out;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            dig_q   <= '0;
            flag_q  <= 1'b0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            dig_q   <= dig_d;
            flag_q  <= flag_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = rst_n && (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign bcd_out   = bcd_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: a 3-digit and a 2-digit instance driven in
// lockstep, checked against hand values and a decimal reference model.
module tb_bin_to_bcd_seq;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  bin_in = '0;
    logic        in_ready, out_valid, ovf;
    logic [11:0] bcd_out;
    logic        in_ready2, out_valid2, ovf2;
    logic [7:0]  bcd2;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .bin_in(bin_in), .out_valid(out_valid), .out_ready(out_ready),
        .bcd_out(bcd_out), .ovf(ovf)
    );

    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .bin_in(bin_in), .out_valid(out_valid2), .out_ready(out_ready),
        .bcd_out(bcd2), .ovf(ovf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] bcd3(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic digits_ok(input logic [11:0] b);
        return (b[3:0] <= 4'd9) && (b[7:4] <= 4'd9) && (b[11:8] <= 4'd9);
    endfunction

    // Leaves the bench at the negedge right after the accepting edge.
    task automatic send(input logic [7:0] v);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1);
        in_valid = 1'b1;
        bin_in   = v;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("done_timeout", out_valid, 1);
    endtask

    task automatic take();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        logic [11:0] exp12;
        logic [7:0]  exp8;
        logic [7:0]  words [3];
        logic [11:0] res   [3];
        int          t     [3];
        int          k_in, k_out;

        // reset state, held low across edges
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_bcd", bcd_out, 0);
        chk("rst_ovf", ovf, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_in_ready", in_ready, 1);
        out_ready = 1'b1;
        @(negedge clk);
        chk("idle_ignore_out_ready", out_valid, 0);
        out_ready = 1'b0;

        // zero
        send(8'd0);
        wait_done(lat);
        chk("zero_latency", lat, 8);
        chk("zero_bcd", bcd_out, 12'h000);
        chk("zero_ovf", ovf, 0);
        take();
        chk("zero_out_valid_drop", out_valid, 0);
        chk("zero_bcd_kept", bcd_out, 12'h000);

        // max value
        send(8'd255);
        wait_done(lat);
        chk("max_latency", lat, 8);
        chk("max_bcd", bcd_out, 12'h255);
        chk("max_ovf", ovf, 0);
        take();
        chk("max_bcd_kept", bcd_out, 12'h255);

        // full sweep, both instances
        for (int v = 0; v < 256; v++) begin
            send(8'(v));
            wait_done(lat);
            exp12 = bcd3(v);
            exp8  = exp12[7:0];
            chk("sweep_bcd", bcd_out, exp12);
            chk("sweep_ovf", ovf, 0);
            chk("sweep_digits", digits_ok(bcd_out), 1);
            chk("sweep_xs3_units", bcd_out[3:0] + 4'd3, exp12[3:0] + 4'd3);
            chk("sweep2_bcd", bcd2, exp8);
            chk("sweep2_ovf", ovf2, (v > 99) ? 1 : 0);
            take();
        end

        // two-digit overflow
        send(8'd123);
        wait_done(lat);
        chk("d2_123_bcd", bcd2, 8'h23);
        chk("d2_123_ovf", ovf2, 1);
        chk("d3_123_bcd", bcd_out, 12'h123);
        take();
        send(8'd99);
        wait_done(lat);
        chk("d2_99_bcd", bcd2, 8'h99);
        chk("d2_99_ovf", ovf2, 0);
        take();

        // backpressure, and a second word held during SHIFT/DONE
        send(8'd77);
        in_valid = 1'b1;
        bin_in   = 8'd5;
        wait_done(lat);
        chk("bp_latency", lat, 8);
        chk("bp_bcd", bcd_out, 12'h077);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_bcd_stable", bcd_out, 12'h077);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_idle_in_ready", in_ready, 1);
        chk("bp_idle_out_valid", out_valid, 0);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_second_accepted", in_ready, 0);
        wait_done(lat);
        chk("bp_second_latency", lat, 8);
        chk("bp_second_bcd", bcd_out, 12'h005);
        take();

        // asynchronous reset in the middle of SHIFT
        send(8'd200);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_bcd", bcd_out, 0);
        chk("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'd42);
        wait_done(lat);
        chk("post_rst_latency", lat, 8);
        chk("post_rst_bcd", bcd_out, 12'h042);
        take();

        // streaming with both handshakes tied high
        words[0] = 8'd7; words[1] = 8'd200; words[2] = 8'd58;
        k_in = 0;
        k_out = 0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            @(negedge clk);
            if (out_valid && k_out < 3) begin
                res[k_out] = bcd_out;
                t[k_out]   = cyc;
                k_out++;
            end
            if (in_ready) begin
                if (k_in < 3) begin
                    in_valid = 1'b1;
                    bin_in   = words[k_in];
                    k_in++;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("stream_count", k_out, 3);
        if (k_out == 3) begin
            chk("stream_res0", res[0], 12'h007);
            chk("stream_res1", res[1], 12'h200);
            chk("stream_res2", res[2], 12'h058);
            chk("stream_gap01", t[1] - t[0], 10);
            chk("stream_gap12", t[2] - t[1], 10);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
